// File: rtl/front_panel_seq_pkg.sv
// Shared encodings for the front-panel sequencer: CPU major states, panel op codes,
// FSM state types and small state-class helpers.
package front_panel_seq_pkg;

  typedef enum logic [4:0] {
    H0 = 5'd0,  HW = 5'd1,  H1 = 5'd2,  H2 = 5'd3,  H3 = 5'd4,
    F0 = 5'd5,  FW = 5'd6,  F1 = 5'd7,  F2 = 5'd8,  F3 = 5'd9,
    D0 = 5'd10, DW = 5'd11, D1 = 5'd12, D2 = 5'd13, D3 = 5'd14,
    E0 = 5'd15, EW = 5'd16, E1 = 5'd17, E2 = 5'd18, E3 = 5'd19
  } major_state_e;

  localparam logic [4:0] MS_LAST = 5'd19;

  typedef enum logic [2:0] {
    FP_NONE = 3'd0, FP_LA = 3'd1, FP_ELA = 3'd2, FP_DEP = 3'd3, FP_EXAM = 3'd4
  } fp_op_e;

  typedef enum logic [2:0] {
    OP_IDLE, OP_ARMED, OP_TRIG, OP_WAIT_DONE, OP_RELEASE
  } op_state_e;

  typedef enum logic [1:0] {
    C_IDLE, C_ASSERT, C_RELEASE
  } cont_state_e;

  function automatic logic st_legal(input logic [4:0] s);
    return s <= MS_LAST;
  endfunction

  function automatic logic st_halted(input logic [4:0] s);
    return s inside {H0, HW, H1, H2, H3};
  endfunction

  function automatic logic st_wait(input logic [4:0] s);
    return s inside {H0, F0, D0, E0};
  endfunction

  function automatic logic st_step(input logic [4:0] s);
    return s inside {FW, DW, EW};
  endfunction

  // p[0]=LA, p[1]=ELA, p[2]=DEP, p[3]=EXAM; lowest index wins
  function automatic fp_op_e pick_op(input logic [3:0] p);
    if (p[0]) return FP_LA;
    if (p[1]) return FP_ELA;
    if (p[2]) return FP_DEP;
    if (p[3]) return FP_EXAM;
    return FP_NONE;
  endfunction

endpackage

// File: rtl/front_panel_seq_debounce.sv
// Per-switch 2-flop synchronizer plus counter debouncer.
// FP_DEBOUNCE_EN undefined: synchronizer only (2-cycle latency, DEBOUNCE_CYCLES ignored).
module fp_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  output logic level_o,
  output logic settled_o
);
`ifdef FP_DEBOUNCE_EN
  localparam bit DebounceOn = 1'b1;
`else
  localparam bit DebounceOn = 1'b0;
`endif
  localparam logic [15:0] EffCycles = DebounceOn ? DEBOUNCE_CYCLES : 16'd0;

  logic meta_q;
  logic level_q;

  // The synchronizer keeps sampling through reset so a switch held across reset
  // shows up as "not settled" and cannot masquerade as a fresh press.
  always_ff @(posedge clk_i) meta_q <= sw_i;

  if (EffCycles == 16'd0) begin : g_sync
    always_ff @(posedge clk_i) begin
      if (!rst_ni) level_q <= 1'b0;
      else         level_q <= meta_q;
    end
    assign settled_o = (meta_q == level_q);
  end else begin : g_cnt
    logic        sync_q;
    logic [15:0] cnt_q;
    always_ff @(posedge clk_i) sync_q <= meta_q;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        level_q <= 1'b0;
        cnt_q   <= '0;
      end else if (sync_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == EffCycles - 16'd1) begin
        level_q <= sync_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign settled_o = (sync_q == level_q);
  end

  assign level_o = level_q;

endmodule

// File: rtl/front_panel_seq.sv
// Front-panel sequencer: debounced panel switches -> halt/single_step levels and
// cont/trigger handshakes with the CPU major-state machine. Option macro: FP_DEBOUNCE_EN.
module front_panel_seq
  import front_panel_seq_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_halt,
  input  logic       sw_sing_step,
  input  logic       sw_cont,
  input  logic       sw_addr_load,
  input  logic       sw_ext_addr_load,
  input  logic       sw_dep,
  input  logic       sw_exam,
  input  logic [4:0] state,
  output logic       halt,
  output logic       single_step,
  output logic       cont,
  output logic       trigger,
  output logic [2:0] fp_op
);
  logic [6:0] sw_raw, lvl, settled;
  logic [4:0] mom_lvl, mom_settled, mom_prev_q, mom_prev_d, mom_press;
  logic [3:0] op_press;
  logic       cont_press, legal, halted, waiting, stepping;
  logic       unused_settled;

  op_state_e   op_st_q;
  cont_state_e cst_q;
  fp_op_e      fp_op_q;
  logic        trigger_q, cont_q;

  assign sw_raw = {sw_exam, sw_dep, sw_ext_addr_load, sw_addr_load,
                   sw_cont, sw_sing_step, sw_halt};

  for (genvar i = 0; i < 7; i++) begin : g_db
    fp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i    (clk),
      .rst_ni   (reset),
      .sw_i     (sw_raw[i]),
      .level_o  (lvl[i]),
      .settled_o(settled[i])
    );
  end

  assign halt           = lvl[0];
  assign single_step    = lvl[1];
  assign unused_settled = ^settled[1:0];

  // bit0 = CONT, bits 4:1 = LA, ELA, DEP, EXAM
  assign mom_lvl     = lvl[6:2];
  assign mom_settled = settled[6:2];
  // prev stays high after reset until the switch is seen settled low, so only a
  // genuine low->high transition counts as a press.
  assign mom_prev_d  = mom_lvl | (mom_prev_q & ~mom_settled);
  assign mom_press   = mom_lvl & ~mom_prev_q;
  assign op_press    = mom_press[4:1];
  assign cont_press  = mom_press[0];

  assign legal    = st_legal(state);
  assign halted   = st_halted(state);
  assign waiting  = st_wait(state);
  assign stepping = st_step(state);

  always_ff @(posedge clk) begin
    if (!reset) mom_prev_q <= '1;
    else        mom_prev_q <= mom_prev_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_st_q   <= OP_RELEASE;
      trigger_q <= 1'b0;
      fp_op_q   <= FP_NONE;
    end else if (legal) begin
      case (op_st_q)
        OP_IDLE: if (|op_press) begin
          if (halted && cst_q != C_ASSERT) begin
            fp_op_q <= pick_op(op_press);
            op_st_q <= OP_ARMED;
          end else begin
            op_st_q <= OP_RELEASE;
          end
        end
        OP_ARMED: if (state == H0) begin
          trigger_q <= 1'b1;
          op_st_q   <= OP_TRIG;
        end
        OP_TRIG: if (state == H1) begin
          trigger_q <= 1'b0;
          op_st_q   <= OP_WAIT_DONE;
        end
        OP_WAIT_DONE: if (state == H3) begin
          fp_op_q <= FP_NONE;
          op_st_q <= OP_RELEASE;
        end
        OP_RELEASE: if (mom_lvl == '0) op_st_q <= OP_IDLE;
        default: op_st_q <= OP_RELEASE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cst_q  <= C_RELEASE;
      cont_q <= 1'b0;
    end else if (legal) begin
      case (cst_q)
        C_IDLE: if (cont_press) begin
          if (op_st_q == OP_IDLE && op_press == '0) begin
            cst_q  <= C_ASSERT;
            cont_q <= waiting;
          end else begin
            cst_q  <= C_RELEASE;
          end
        end
        C_ASSERT: begin
          if (stepping) begin
            cont_q <= 1'b0;
            cst_q  <= C_RELEASE;
          end else if (waiting) begin
            cont_q <= 1'b1;
          end
        end
        C_RELEASE: if (!mom_lvl[0]) cst_q <= C_IDLE;
        default: cst_q <= C_RELEASE;
      endcase
    end
  end

  assign cont    = cont_q;
  assign trigger = trigger_q;
  assign fp_op   = fp_op_q;

endmodule
